// File: rtl/mfcc_match_sched.sv
// Template-matching scan controller: streams query/template coefficient
// differences into an external squarer, accumulates distances, keeps the minimum.
module mfcc_match_sched #(
   parameter int NUM_TPL  = 4,
   parameter int NUM_COEF = 13,
   parameter int MUL_LAT  = 3,
   parameter int DIST_W   = 38
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic [NUM_TPL-1:0]                          tpl_mask,
   input  logic [DIST_W-1:0]                           threshold,
   output logic [$clog2(NUM_COEF)-1:0]                 q_addr,
   input  logic signed [15:0]                          q_data,
   output logic [$clog2(NUM_TPL)+$clog2(NUM_COEF)-1:0] t_addr,
   input  logic signed [15:0]                          t_data,
   output logic signed [16:0]                          mul_a,
   input  logic [33:0]                                 mul_p,
   output logic                                        busy,
   output logic                                        done,
   output logic [$clog2(NUM_TPL+1)-1:0]                match_idx,
   output logic                                        match_valid,
   output logic [DIST_W-1:0]                           min_dist
);

   localparam int TW = $clog2(NUM_TPL);
   localparam int CW = $clog2(NUM_COEF);
   localparam int IW = $clog2(NUM_TPL+1);
   localparam int TD = 2 + MUL_LAT;

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, COMPARE, SKIP, DONE} state_t;

   state_t              state;
   logic [TW-1:0]       tpl;
   logic [NUM_TPL-1:0]  mask_r;
   logic [DIST_W-1:0]   thr_r;
   logic [DIST_W-1:0]   best;
   logic [IW-1:0]       best_idx;
   logic [DIST_W-1:0]   acc;
   logic [TD-1:0]       tag;

   logic signed [16:0]  diff;
   logic [DIST_W:0]     acc_sum;
   logic [DIST_W-1:0]   acc_sat;
   logic [DIST_W-1:0]   best_nxt;
   logic [IW-1:0]       idx_nxt;
   logic                mv_nxt;
   logic                last_tpl;
   logic [TW-1:0]       nxt_tpl;

   always_comb begin
      diff     = {q_data[15], q_data} - {t_data[15], t_data};
      acc_sum  = {1'b0, acc} + (DIST_W+1)'(mul_p);
      acc_sat  = acc_sum[DIST_W] ? '1 : acc_sum[DIST_W-1:0];
      best_nxt = best;
      idx_nxt  = best_idx;
      // Strict compare keeps the lower index on ties.
      if (state == COMPARE && acc < best) begin
         best_nxt = acc;
         idx_nxt  = IW'(tpl);
      end
      mv_nxt   = (idx_nxt != IW'(NUM_TPL)) && (best_nxt <= thr_r);
      last_tpl = (tpl == TW'(NUM_TPL-1));
      nxt_tpl  = tpl + 1'b1;
   end

   // Datapath: tag pipeline tracks each issued address through RAM and squarer.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag   <= '0;
         mul_a <= '0;
         acc   <= '0;
      end else begin
         tag   <= {tag[TD-2:0], state == ISSUE};
         mul_a <= tag[0] ? diff : '0;
         if (state == COMPARE)
            acc <= '0;
         else if (tag[TD-1])
            acc <= acc_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tpl         <= '0;
         mask_r      <= '0;
         thr_r       <= '0;
         best        <= '1;
         best_idx    <= IW'(NUM_TPL);
         q_addr      <= '0;
         t_addr      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         match_idx   <= IW'(NUM_TPL);
         match_valid <= 1'b0;
         min_dist    <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mask_r   <= tpl_mask;
               thr_r    <= threshold;
               tpl      <= '0;
               best     <= '1;
               best_idx <= IW'(NUM_TPL);
               q_addr   <= '0;
               t_addr   <= '0;
               busy     <= 1'b1;
               state    <= tpl_mask[0] ? ISSUE : SKIP;
            end
            ISSUE: begin
               if (q_addr == CW'(NUM_COEF-1)) begin
                  state <= DRAIN;
               end else begin
                  q_addr <= q_addr + 1'b1;
                  t_addr <= {tpl, q_addr + 1'b1};
               end
            end
            DRAIN: if (tag == '0) state <= COMPARE;
            COMPARE, SKIP: begin
               best     <= best_nxt;
               best_idx <= idx_nxt;
               if (last_tpl) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  min_dist    <= best_nxt;
                  match_valid <= mv_nxt;
                  match_idx   <= mv_nxt ? idx_nxt : IW'(NUM_TPL);
               end else begin
                  tpl    <= nxt_tpl;
                  q_addr <= '0;
                  t_addr <= {nxt_tpl, CW'(0)};
                  state  <= mask_r[nxt_tpl] ? ISSUE : SKIP;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mfcc_match_sched.sv
// Directed bench for mfcc_match_sched with behavioural RAMs and a 3-stage squarer.
module tb_mfcc_match_sched;

   localparam logic [63:0] ONES38 = 64'h0000_003F_FFFF_FFFF;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [3:0]         tpl_mask = '0;
   logic [37:0]        threshold = '0;
   logic [3:0]         q_addr;
   logic signed [15:0] q_data;
   logic [5:0]         t_addr;
   logic signed [15:0] t_data;
   logic signed [16:0] mul_a;
   logic [33:0]        mul_p;
   logic               busy;
   logic               done;
   logic [2:0]         match_idx;
   logic               match_valid;
   logic [37:0]        min_dist;

   logic signed [15:0] q_mem [16];
   logic signed [15:0] t_mem [64];
   logic signed [33:0] sq;
   logic [33:0]        p1, p2;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   mfcc_match_sched #(.NUM_TPL(4), .NUM_COEF(13), .MUL_LAT(3), .DIST_W(38)) dut (
      .clk(clk), .rst(rst), .start(start), .tpl_mask(tpl_mask), .threshold(threshold),
      .q_addr(q_addr), .q_data(q_data), .t_addr(t_addr), .t_data(t_data),
      .mul_a(mul_a), .mul_p(mul_p), .busy(busy), .done(done),
      .match_idx(match_idx), .match_valid(match_valid), .min_dist(min_dist)
   );

   always #5 clk = ~clk;

   assign sq = mul_a * mul_a;
   always @(posedge clk) begin
      q_data <= q_mem[q_addr];
      t_data <= t_mem[t_addr];
      p1     <= $unsigned(sq);
      p2     <= p1;
      mul_p  <= p2;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      assert (act === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic load_step();
      for (int c = 0; c < 16; c++) q_mem[c] = (c < 13) ? 16'sd100 : 16'sd0;
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < 16; c++)
            t_mem[k*16+c] = (c < 13) ? 16'(100 + 8*(k-2)) : 16'sd0;
   endtask

   task automatic run_scan(input string name, input logic [3:0] mask, input logic [37:0] thr,
                           input int repulse, input int exp_done, input int exp_blast,
                           input int exp_idx, input int exp_valid, input logic [63:0] exp_min);
      int done_cyc, done_cnt, busy_first, busy_last;
      done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
      @(negedge clk);
      tpl_mask = mask; threshold = thr; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; tpl_mask = ~mask; threshold = '0;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         start = (cyc == repulse);
         if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
      chk({name, ".done_count"}, 64'(done_cnt), 64'd1);
      chk({name, ".busy_first"}, 64'(busy_first), 64'd1);
      chk({name, ".busy_last"}, 64'(busy_last), 64'(exp_blast));
      chk({name, ".match_idx"}, 64'(match_idx), 64'(exp_idx));
      chk({name, ".match_valid"}, 64'(match_valid), 64'(exp_valid));
      chk({name, ".min_dist"}, 64'(min_dist), exp_min);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) q_mem[i] = '0;
      for (int i = 0; i < 64; i++) t_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.match_valid", 64'(match_valid), 64'd0);
      chk("reset.match_idx", 64'(match_idx), 64'd4);
      chk("reset.min_dist", 64'(min_dist), ONES38);
      chk("reset.q_addr", 64'(q_addr), 64'd0);
      chk("reset.t_addr", 64'(t_addr), 64'd0);
      chk("reset.mul_a", 64'(mul_a), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Template 2 equals the query; neighbours at 832 and 3328.
      load_step();
      run_scan("all_en", 4'b1111, 38'd1000, 0, 81, 80, 2, 1, 64'd0);
      run_scan("restart", 4'b1111, 38'd1000, 10, 81, 80, 2, 1, 64'd0);
      run_scan("mask8", 4'b1000, 38'd1000, 0, 24, 23, 3, 1, 64'd832);
      run_scan("thr_eq", 4'b1010, 38'd832, 0, 43, 42, 1, 1, 64'd832);
      run_scan("thr_lo", 4'b1010, 38'd831, 0, 43, 42, 4, 0, 64'd832);
      run_scan("mask0", 4'b0000, 38'd1000, 0, 5, 4, 4, 0, ONES38);

      // Templates 0 and 3 both at distance 13: lower index wins.
      for (int c = 0; c < 13; c++) begin
         q_mem[c]    = 16'(c*100 - 600);
         t_mem[c]    = 16'(c*100 - 600 + 1);
         t_mem[16+c] = 16'(c*100 - 600 + 50);
         t_mem[32+c] = 16'(c*100 - 600 - 50);
         t_mem[48+c] = 16'(c*100 - 600 - 1);
      end
      run_scan("tie", 4'b1111, 38'd1000, 0, 81, 80, 0, 1, 64'd13);

      for (int c = 0; c < 13; c++) begin
         q_mem[c] = 16'sh7FFF;
         t_mem[c] = 16'sh8000;
      end
      run_scan("extreme", 4'b0001, 38'd12, 0, 24, 23, 4, 0, 64'd55832870925);

      // Reset in the middle of a scan.
      load_step();
      @(negedge clk);
      tpl_mask = 4'b1111; threshold = 38'd1000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (29) begin @(posedge clk); #1; end
      chk("midrst.busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.done", 64'(done), 64'd0);
      chk("midrst.match_idx", 64'(match_idx), 64'd4);
      chk("midrst.match_valid", 64'(match_valid), 64'd0);
      chk("midrst.min_dist", 64'(min_dist), ONES38);
      chk("midrst.mul_a", 64'(mul_a), 64'd0);
      begin
         int dcnt, bcnt;
         dcnt = 0; bcnt = 0;
         repeat (100) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (busy) bcnt++;
         end
         chk("midrst.no_done", 64'(dcnt), 64'd0);
         chk("midrst.stay_idle", 64'(bcnt), 64'd0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mfcc_match_sched.md
# mfcc_match_sched

Controller for the MFCC template-matching datapath. On `start`, it runs through up to `NUM_TPL` enrolled templates. For each one it reads the query and template coefficients from external RAMs and feeds their difference into the shared pipelined 17x17 squarer. It then accumulates the squared distances and tracks the minimum. It sits between the feature RAMs and the key/LED front end, and replaces inline recognition sequencing with a start/done handshake.

## Interface
- `NUM_TPL`, 4, number of template slots.
- `NUM_COEF`, 13, coefficients per vector.
- `MUL_LAT`, 3, squarer latency in cycles from `mul_a` to `mul_p`; the squarer has ce tied high.
- `DIST_W`, 38, accumulator and distance width.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request, accepted only in IDLE.
- `tpl_mask` in `NUM_TPL`: bit k set means template k is enrolled; sampled at start.
- `threshold` in `DIST_W`: maximum accepted distance; sampled at start.
- `q_addr` out clog2(`NUM_COEF`): query RAM address.
- `q_data` in 16 signed: query RAM data, available 1 cycle after address.
- `t_addr` out clog2(`NUM_TPL`)+clog2(`NUM_COEF`): template RAM address, {template, coef}.
- `t_data` in 16 signed: template RAM data, available 1 cycle after address.
- `mul_a` out 17 signed: squarer operand, registered.
- `mul_p` in 34: squarer product, unsigned.
- `busy` out 1: a scan is in progress.
- `done` out 1: one-cycle pulse when results are updated.
- `match_idx` out clog2(`NUM_TPL`+1): best template index, or `NUM_TPL` for no match.
- `match_valid` out 1: a best template exists and its distance is ≤ `threshold`.
- `min_dist` out `DIST_W`: minimum distance of the last scan.

## Operation
- States and transitions:
  - IDLE → on `start`: latch `tpl_mask` and `threshold`; set tpl=0, best=all-ones, best_idx=`NUM_TPL`.
  - From IDLE, go to ISSUE if `tpl_mask[0]`, otherwise SKIP.
  - ISSUE: `NUM_COEF` consecutive cycles.
    - Drive `q_addr`=c and `t_addr`={tpl,c} for c=0..`NUM_COEF`-1.
    - Push a valid tag into a shift register of depth 2+`MUL_LAT`.
  - DRAIN: wait until the tag pipeline is empty and the last product has been accumulated.
  - COMPARE: one cycle.
    - If acc < best (strict), set best=acc and best_idx=tpl.
    - Clear acc, then advance tpl.
  - SKIP: one cycle for a masked template; no compare; advance tpl.
  - Advance rule: the next template goes to ISSUE or SKIP according to its mask bit. After template `NUM_TPL`-1, go to DONE.
  - DONE: one cycle. Assert `done` and update the outputs, then return to IDLE.
- Datapath pipeline, with address cycle t:
  - t+1: RAM data is valid.
  - t+2: `mul_a` = sign-extended `q_data` − `t_data`.
  - t+2+`MUL_LAT`: `mul_p` is valid.
  - t+3+`MUL_LAT`: the product is added into acc.
- `mul_a` is driven to 0 when its tag is not valid.
- Accumulator rules:
  - The accumulator is unsigned and saturates at all-ones.
  - With default parameters saturation cannot occur: maximum 13·65535² < 2^36.
- Results written in DONE:
  - `min_dist`=best.
  - `match_valid` = (best_idx≠`NUM_TPL`) && (best ≤ `threshold`).
  - `match_idx` = best_idx if `match_valid`, otherwise `NUM_TPL`.
  - `min_dist` reports the true minimum even when the match is rejected.
- Ties go to the lower index because the compare is strict less-than.
- `start` outside IDLE, including in DONE, is ignored.
- `busy` = state ∉ {IDLE, DONE}.
- Outputs hold their values between `done` pulses.

## Timing
- Reset values: `busy`=0, `done`=0, `match_valid`=0, `match_idx`=`NUM_TPL`, `min_dist`=all-ones, `q_addr`=0, `t_addr`=0, `mul_a`=0.
- Reset also clears acc, tags and state.
- Reset mid-scan: IDLE on the next cycle, no `done`, and the previous results are cleared to their reset values.
- `start` is sampled at cycle 0; the first ISSUE is at cycle 1.
- An enabled template takes `NUM_COEF`+4+`MUL_LAT` cycles from its first ISSUE cycle through COMPARE: 20 cycles with defaults.
- A masked template takes 1 cycle.
- `done` fires 1 cycle after the last COMPARE or SKIP.
- Defaults with all templates enabled: COMPARE at cycles 20, 40, 60, 80; `done` at 81; `busy` high for cycles 1..80.
- A new `start` is accepted at cycle 82 at the earliest.

## Test plan
- All templates enabled. Query coefs all 100; template k coefs all 100+8·(k−2), so template 2 equals the query. Threshold 1000. → `done` at cycle 81, `match_idx`=2, `min_dist`=0, `match_valid`=1.
- Tie case. Templates 0 and 3 differ by 1 on every coef; templates 1 and 2 differ by 50. → `min_dist`=13, `match_idx`=0.
- `tpl_mask`=4'b1000. → SKIP at cycles 1..3, ISSUE from cycle 4, COMPARE at 23, `done` at 24, `match_idx`=3.
- `tpl_mask`=0. → `done` at cycle 5, `match_valid`=0, `match_idx`=4, `min_dist`=all-ones.
- Extremes. Query +32767 against template −32768 on all coefs, single template, threshold 12. → `min_dist`=55832870925, `match_valid`=0, `match_idx`=4.
- `start` re-pulsed at cycle 10 → ignored; still a single `done` at 81. Separate run: `rst` at cycle 30 → `busy`=0 at 31, no `done`, outputs at reset values.
